cpu_exec_unit: RTL and testbench

CPU_EXEC_UNIT -- requirements
Module: cpu_exec_unit

---
 rtl/exec_pkg.sv | 29 ++
 rtl/exec_alu.sv | 34 +++
 rtl/cpu_exec_unit.sv | 117 +++++++++++
 tb/tb_cpu_exec_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the execution unit: opcode values, ALU function
// encoding and the default datapath width / data-memory depth.
package exec_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 256;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNE   = 4'b0111;
  localparam logic [3:0] OP_JMP   = 4'b1000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_fn_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU. Shifts exist only when EXEC_SHIFT_EN is defined;
// otherwise the shift encodings return zero and no shifter is built.
module exec_alu
  import exec_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_fn_e      fn_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (fn_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
`ifdef EXEC_SHIFT_EN
      ALU_SLL: y_o = a_i << b_i[2:0];
      ALU_SRL: y_o = a_i >> b_i[2:0];
`else
      ALU_SLL: y_o = '0;
      ALU_SRL: y_o = '0;
`endif
      ALU_SLT: y_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_exec_unit.sv
// Single-cycle execute stage: opcode decode, ALU, branch resolve and a byte
// data memory. Optional shifts are enabled with the EXEC_SHIFT_EN macro.
module cpu_exec_unit
  import exec_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   opcode,
  input  logic [2:0]   func,
  input  logic [W-1:0] ra,
  input  logic [W-1:0] rb,
  input  logic [W-1:0] imm,
  output logic         reg_dst,
  output logic         reg_write,
  output logic         alusrc,
  output logic [2:0]   alufn,
  output logic         mem_read,
  output logic         mem_write,
  output logic         mem_to_reg,
  output logic         nia,
  output logic         br,
  output logic [W-1:0] aluout,
  output logic [W-1:0] mem_out,
  output logic [W-1:0] wb_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  alu_fn_e       alu_fn;
  logic          is_beq;
  logic          is_bne;
  logic          zero;
  logic [W-1:0]  alu_b;
  logic [AW-1:0] addr;
  logic [W-1:0]  mem_q [DEPTH];

  // NOTE: every output is given a default before the case so that no path
  // leaves a signal unassigned; an unassigned path would infer a latch.
  always_comb begin
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alusrc     = 1'b0;
    alu_fn     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    nia        = 1'b1;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_fn    = alu_fn_e'(func);
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        alu_fn    = (opcode == OP_ADDI) ? ALU_ADD :
                    (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        alusrc    = 1'b1;
        reg_write = 1'b1;
      end
      OP_LW: begin
        alusrc     = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      OP_SW: begin
        alusrc    = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        alu_fn = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_BNE: begin
        alu_fn = ALU_SUB;
        is_bne = 1'b1;
      end
      OP_JMP:  nia = 1'b0;
      default: ;
    endcase
  end

  assign alufn = alu_fn;
  assign alu_b = alusrc ? imm : rb;

  exec_alu #(.W(W)) u_alu (
    .a_i  (ra),
    .b_i  (alu_b),
    .fn_i (alu_fn),
    .y_o  (aluout)
  );

  assign zero = (aluout == '0);
  assign br   = (is_beq & zero) | (is_bne & ~zero);

  // The ALU result wraps onto a smaller memory rather than going out of range.
  assign addr    = AW'(32'(aluout) % DEPTH);
  assign mem_out = mem_read ? mem_q[addr] : '0;
  assign wb_data = mem_to_reg ? mem_out : aluout;

  // NOTE: the memory is reset on purpose: every byte must read as zero while
  // rst is high, so the array is built from resettable flops, not a RAM macro.
  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_write) begin
      mem_q[addr] <= rb;
    end
  end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Directed bench for cpu_exec_unit: an arithmetic reference model checked
// against every output each cycle, plus hand-computed literal expectations.
module tb_cpu_exec_unit;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [2:0] func;
  logic [7:0] ra, rb, imm;
  logic       reg_dst, reg_write, alusrc, mem_read, mem_write, mem_to_reg, nia, br;
  logic [2:0] alufn;
  logic [7:0] aluout, mem_out, wb_data;

  cpu_exec_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ra(ra), .rb(rb), .imm(imm),
    .reg_dst(reg_dst), .reg_write(reg_write), .alusrc(alusrc), .alufn(alufn),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .nia(nia), .br(br), .aluout(aluout), .mem_out(mem_out), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  typedef struct packed {
    logic       reg_dst, reg_write, alusrc;
    logic [2:0] alufn;
    logic       mem_read, mem_write, mem_to_reg, nia, br;
    logic [7:0] aluout;
  } exp_t;

  logic [7:0] m_mem [256];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: decode table plus plain integer arithmetic on 0..255 values.
  function automatic exp_t model(input logic [3:0] op, input logic [2:0] fn,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] im);
    exp_t e;
    int x, y, res, sh;
    e     = '0;
    e.nia = 1'b1;
    case (op)
      4'd0: begin e.alufn = fn; e.reg_write = 1; e.reg_dst = 1; end
      4'd1: begin e.alufn = 3'd0; e.alusrc = 1; e.reg_write = 1; end
      4'd2: begin e.alufn = 3'd2; e.alusrc = 1; e.reg_write = 1; end
      4'd3: begin e.alufn = 3'd3; e.alusrc = 1; e.reg_write = 1; end
      4'd4: begin e.alusrc = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
      4'd5: begin e.alusrc = 1; e.mem_write = 1; end
      4'd6, 4'd7: e.alufn = 3'd1;
      4'd8: e.nia = 1'b0;
      default: ;
    endcase
    x  = int'(a);
    y  = e.alusrc ? int'(im) : int'(b);
    sh = y % 8;
    case (e.alufn)
      3'd0: res = (x + y) % 256;
      3'd1: res = (x - y + 256) % 256;
      3'd2: res = int'(a & (e.alusrc ? im : b));
      3'd3: res = int'(a | (e.alusrc ? im : b));
      3'd4: res = int'(a ^ (e.alusrc ? im : b));
`ifdef EXEC_SHIFT_EN
      3'd5: res = (x * (1 << sh)) % 256;
      3'd6: res = x / (1 << sh);
`else
      3'd5: res = 0;
      3'd6: res = 0;
`endif
      default: res = (to_signed(x) < to_signed(y)) ? 1 : 0;
    endcase
    e.aluout = 8'(res);
    if (op == 4'd6) e.br = (res == 0);
    if (op == 4'd7) e.br = (res != 0);
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    end else begin
      e = model(opcode, func, ra, rb, imm);
      if (e.mem_write) m_mem[e.aluout] = rb;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] exp_mo, exp_wb;
    if (cmp_en) begin
      e      = model(opcode, func, ra, rb, imm);
      exp_mo = e.mem_read ? m_mem[e.aluout] : 8'h00;
      exp_wb = e.mem_to_reg ? exp_mo : e.aluout;
      check("m_reg_dst",    16'(reg_dst),    16'(e.reg_dst));
      check("m_reg_write",  16'(reg_write),  16'(e.reg_write));
      check("m_alusrc",     16'(alusrc),     16'(e.alusrc));
      check("m_alufn",      16'(alufn),      16'(e.alufn));
      check("m_mem_read",   16'(mem_read),   16'(e.mem_read));
      check("m_mem_write",  16'(mem_write),  16'(e.mem_write));
      check("m_mem_to_reg", 16'(mem_to_reg), 16'(e.mem_to_reg));
      check("m_nia",        16'(nia),        16'(e.nia));
      check("m_br",         16'(br),         16'(e.br));
      check("m_aluout",     16'(aluout),     16'(e.aluout));
      check("m_mem_out",    16'(mem_out),    16'(exp_mo));
      check("m_wb_data",    16'(wb_data),    16'(exp_wb));
    end
  end

  task automatic drive(input logic [3:0] op, input logic [2:0] fn,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] im);
    @(posedge clk);
    #1;
    opcode = op; func = fn; ra = a; rb = b; imm = im;
    #2;
  endtask

  logic [7:0] ops_a [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
  logic [7:0] ops_b [4] = '{8'h01, 8'hFF, 8'h07, 8'h80};

  initial begin
    rst = 1'b1;
    opcode = 4'h0; func = 3'h0; ra = 8'h00; rb = 8'h00; imm = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state of memory
    drive(4'h4, 3'h0, 8'h00, 8'h00, 8'h00);
    check("rst_mem0", 16'(mem_out), 16'h00);
    drive(4'h4, 3'h0, 8'hFF, 8'h00, 8'h00);
    check("rst_memff", 16'(mem_out), 16'h00);

    // Scenario 1
    drive(4'h0, 3'h0, 8'hF0, 8'h20, 8'h00);
    check("s1_aluout", 16'(aluout), 16'h10);
    check("s1_reg_write", 16'(reg_write), 16'h1);
    check("s1_reg_dst", 16'(reg_dst), 16'h1);
    check("s1_wb", 16'(wb_data), 16'h10);

    // Wrap-around boundaries
    drive(4'h0, 3'h0, 8'hFF, 8'h01, 8'h00);
    check("add_wrap", 16'(aluout), 16'h00);
    drive(4'h0, 3'h1, 8'h00, 8'h01, 8'h00);
    check("sub_wrap", 16'(aluout), 16'hFF);

    // Scenario 2
    drive(4'h5, 3'h0, 8'h05, 8'hAB, 8'h03);
    check("s2_sw_addr", 16'(aluout), 16'h08);
    drive(4'h4, 3'h0, 8'h05, 8'h00, 8'h03);
    check("s2_lw_aluout", 16'(aluout), 16'h08);
    check("s2_lw_mem_out", 16'(mem_out), 16'hAB);
    check("s2_lw_wb", 16'(wb_data), 16'hAB);

    // Scenario 3
    drive(4'h6, 3'h0, 8'h33, 8'h33, 8'h00);
    check("s3_beq_eq", 16'(br), 16'h1);
    drive(4'h7, 3'h0, 8'h33, 8'h33, 8'h00);
    check("s3_bne_eq", 16'(br), 16'h0);
    drive(4'h6, 3'h0, 8'h33, 8'h34, 8'h00);
    check("s3_beq_ne", 16'(br), 16'h0);
    drive(4'h7, 3'h0, 8'h33, 8'h34, 8'h00);
    check("s3_bne_ne", 16'(br), 16'h1);

    // Scenario 4
    drive(4'h8, 3'h0, 8'h12, 8'h34, 8'h56);
    check("s4_jmp_nia", 16'(nia), 16'h0);
    check("s4_jmp_rw", 16'(reg_write), 16'h0);
    check("s4_jmp_mw", 16'(mem_write), 16'h0);
    drive(4'hF, 3'h7, 8'h12, 8'h34, 8'h56);
    check("s4_nop_ctl",
          16'({reg_dst, reg_write, alusrc, alufn, mem_read, mem_write, mem_to_reg, br}),
          16'h000);
    check("s4_nop_nia", 16'(nia), 16'h1);

    // Scenario 5
    drive(4'h0, 3'h7, 8'h80, 8'h01, 8'h00);
    check("s5_slt", 16'(aluout), 16'h01);
    drive(4'h0, 3'h5, 8'h03, 8'h02, 8'h00);
`ifdef EXEC_SHIFT_EN
    check("s5_sll", 16'(aluout), 16'h0C);
`else
    check("s5_sll", 16'(aluout), 16'h00);
`endif

    // Immediate ops and all R-type functions over a few operand pairs
    drive(4'h1, 3'h0, 8'hFE, 8'h00, 8'h03);
    check("addi", 16'(aluout), 16'h01);
    drive(4'h2, 3'h0, 8'h3C, 8'hFF, 8'h0F);
    check("andi", 16'(aluout), 16'h0C);
    drive(4'h3, 3'h0, 8'h30, 8'h00, 8'h05);
    check("ori", 16'(aluout), 16'h35);
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < 4; k++)
        drive(4'h0, 3'(f), ops_a[k], ops_b[k], 8'h00);

    // Scenario 6
    drive(4'h5, 3'h0, 8'h05, 8'h55, 8'h03);
    drive(4'h4, 3'h0, 8'h05, 8'h00, 8'h03);
    check("s6_pre", 16'(mem_out), 16'h55);
    rst = 1'b1;
    #1;
    check("s6_rst_clear", 16'(mem_out), 16'h00);
    drive(4'h5, 3'h0, 8'h05, 8'h77, 8'h03);
    drive(4'h4, 3'h0, 8'h05, 8'h00, 8'h03);
    rst = 1'b0;
    #1;
    check("s6_rst_store", 16'(mem_out), 16'h00);
    drive(4'h4, 3'h0, 8'h05, 8'h00, 8'h03);
    check("s6_after", 16'(mem_out), 16'h00);

    @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
